// File: rtl/pp_requant_if.sv
// rtl/pp_requant_if.sv - valid/ready beat stream carrying packed data and an OFM address
interface pp_requant_if #(
  parameter int DW = 32,
  parameter int AW = 16
);
  logic          vld;
  logic          ready;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;

  modport master (output vld, data, addr, input ready);
  modport slave  (input vld, data, addr, output ready);
endinterface

// File: rtl/pp_requant.sv
// rtl/pp_requant.sv - per-channel bias/scale requantization, rounding shift, leaky act, int8 pack
module pp_requant #(
  parameter int TOUT      = 4,
  parameter int PSUM_DW   = 32,
  parameter int BIAS_DW   = 16,
  parameter int SCALES_DW = 16,
  parameter int W_OUT     = 8,
  parameter int W_CHANNEL = 8,
  parameter int OFM_AW    = 16,
  parameter int TBL_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [4:0]                   q_shift_i,
  input  logic                         q_act_i,
  input  logic                         q_start_i,
  input  logic [OFM_AW:0]              q_num_words_i,
  input  logic                         tbl_we_i,
  input  logic [W_CHANNEL-1:0]         tbl_addr_i,
  input  logic [TOUT*BIAS_DW-1:0]      tbl_bias_i,
  input  logic [TOUT*SCALES_DW-1:0]    tbl_scale_i,
  input  logic [W_CHANNEL-1:0]         in_chn_i,
  pp_requant_if.slave                  in_if,
  pp_requant_if.master                 out_if,
  output logic                         done_o
);
  localparam int SW     = PSUM_DW + 1;
  localparam int PW     = PSUM_DW + SCALES_DW + 1;
  localparam int RW     = PW + 1;
  localparam int OFM_DW = TOUT * W_OUT;
  localparam logic signed [RW-1:0] SAT_HI = (RW'(1) <<< (W_OUT - 1)) - RW'(1);
  localparam logic signed [RW-1:0] SAT_LO = -SAT_HI - RW'(1);

  logic [TOUT*BIAS_DW-1:0]   bias_mem  [TBL_DEPTH];
  logic [TOUT*SCALES_DW-1:0] scale_mem [TBL_DEPTH];

  logic                         stall, accept, hs;
  logic                         s1_vld_q, s2_vld_q, s3_vld_q, o_vld_q;
  logic [TOUT*PSUM_DW-1:0]      s1_psum_q;
  logic [TOUT*BIAS_DW-1:0]      s1_bias_q;
  logic [TOUT*SCALES_DW-1:0]    s1_scale_q, s2_scale_q;
  logic [OFM_AW-1:0]            s1_addr_q, s2_addr_q, s3_addr_q, o_addr_q;
  logic signed [SW-1:0]         s2_sum_d  [TOUT];
  logic signed [SW-1:0]         s2_sum_q  [TOUT];
  logic signed [PW-1:0]         s3_prod_d [TOUT];
  logic signed [PW-1:0]         s3_prod_q [TOUT];
  logic signed [RW-1:0]         half, r;
  logic [OFM_DW-1:0]            o_data_d, o_data_q;
  logic [OFM_AW:0]              cnt_d, cnt_q;
  logic                         done_d, done_q;

  assign stall       = o_vld_q && !out_if.ready;
  assign hs          = o_vld_q && out_if.ready;
  assign in_if.ready = !stall && !tbl_we_i;
  assign accept      = in_if.vld && in_if.ready;

  assign out_if.vld  = o_vld_q;
  assign out_if.data = o_data_q;
  assign out_if.addr = o_addr_q;
  assign done_o      = done_q;

  always_ff @(posedge clk) begin
    if (tbl_we_i) begin
      bias_mem[tbl_addr_i]  <= tbl_bias_i;
      scale_mem[tbl_addr_i] <= tbl_scale_i;
    end
  end

  always_comb begin
    for (int l = 0; l < TOUT; l++) begin
      s2_sum_d[l]  = SW'($signed(s1_psum_q[l*PSUM_DW +: PSUM_DW]))
                   + SW'($signed(s1_bias_q[l*BIAS_DW +: BIAS_DW]));
      s3_prod_d[l] = PW'(s2_sum_q[l]) * PW'($signed(s2_scale_q[l*SCALES_DW +: SCALES_DW]));
    end
  end

  // half is 0 for a zero shift, so the same add-and-shift covers the pass-through case
  assign half = (RW'(1) << q_shift_i) >>> 1;

  always_comb begin
    o_data_d = '0;
    r        = '0;
    for (int l = 0; l < TOUT; l++) begin
      r = (RW'(s3_prod_q[l]) + half) >>> q_shift_i;
      if (q_act_i && r < 0) r = r >>> 3;
      if (r > SAT_HI)      r = SAT_HI;
      else if (r < SAT_LO) r = SAT_LO;
      o_data_d[l*W_OUT +: W_OUT] = r[W_OUT-1:0];
    end
  end

  // A start pulse wins over a coincident handshake; the count freezes once it reaches the target.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (q_start_i) begin
      cnt_d = '0;
    end else if (hs && (q_num_words_i == '0 || cnt_q != q_num_words_i)) begin
      cnt_d  = cnt_q + (OFM_AW+1)'(1);
      done_d = (q_num_words_i != '0) && (cnt_d == q_num_words_i);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s3_vld_q   <= 1'b0;
      o_vld_q    <= 1'b0;
      s1_psum_q  <= '0;
      s1_bias_q  <= '0;
      s1_scale_q <= '0;
      s2_scale_q <= '0;
      s1_addr_q  <= '0;
      s2_addr_q  <= '0;
      s3_addr_q  <= '0;
      o_addr_q   <= '0;
      o_data_q   <= '0;
      for (int l = 0; l < TOUT; l++) begin
        s2_sum_q[l]  <= '0;
        s3_prod_q[l] <= '0;
      end
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      if (!stall) begin
        s1_vld_q <= accept;
        s2_vld_q <= s1_vld_q;
        s3_vld_q <= s2_vld_q;
        o_vld_q  <= s3_vld_q;
        if (accept) begin
          s1_psum_q  <= in_if.data;
          s1_addr_q  <= in_if.addr;
          s1_bias_q  <= bias_mem[in_chn_i];
          s1_scale_q <= scale_mem[in_chn_i];
        end
        s2_sum_q   <= s2_sum_d;
        s2_scale_q <= s1_scale_q;
        s2_addr_q  <= s1_addr_q;
        s3_prod_q  <= s3_prod_d;
        s3_addr_q  <= s2_addr_q;
        o_data_q   <= o_data_d;
        o_addr_q   <= s3_addr_q;
      end
    end
  end
endmodule

// File: tb/tb_pp_requant.sv
// tb/tb_pp_requant.sv - vector table plus scoreboard bench for pp_requant
module tb_pp_requant;
  localparam int TOUT = 4, PDW = 32, WO = 8, CW = 8, AW = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]    q_shift;
  logic          q_act, q_start;
  logic [AW:0]   q_num_words;
  logic          tbl_we;
  logic [CW-1:0] tbl_addr, in_chn;
  logic [63:0]   tbl_bias, tbl_scale;
  logic          done;

  pp_requant_if #(.DW(TOUT*PDW), .AW(AW)) in_if ();
  pp_requant_if #(.DW(TOUT*WO),  .AW(AW)) out_if ();

  pp_requant dut (
    .clk(clk), .rstn(rstn),
    .q_shift_i(q_shift), .q_act_i(q_act), .q_start_i(q_start), .q_num_words_i(q_num_words),
    .tbl_we_i(tbl_we), .tbl_addr_i(tbl_addr), .tbl_bias_i(tbl_bias), .tbl_scale_i(tbl_scale),
    .in_chn_i(in_chn), .in_if(in_if), .out_if(out_if), .done_o(done)
  );

  typedef struct packed { logic [31:0] data; logic [15:0] addr; } exp_t;
  typedef struct packed {
    logic [4:0] sh; logic act; logic [7:0] chn; logic [127:0] ps; logic [31:0] ex;
  } vec_t;

  exp_t sb_q[$];
  int total = 0, bad = 0;
  int cyc = 0, hs_cyc = 0, hs_total = 0, done_cyc = 0, done_cnt = 0, vld_seen = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] hold_data;
  logic [15:0] hold_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] pk128(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] pk32(input int a, input int b, input int c, input int d);
    logic [31:0] w;
    w = {d[7:0], c[7:0], b[7:0], a[7:0]};
    return w;
  endfunction

  function automatic vec_t mkvec(input int sh, input logic act, input int chn,
                                 input logic [127:0] ps, input logic [31:0] ex);
    vec_t v;
    v.sh = sh[4:0]; v.act = act; v.chn = chn[7:0]; v.ps = ps; v.ex = ex;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_if.vld) vld_seen++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (stall_prev && out_if.vld) begin
      check("stable_data", out_if.data, hold_data);
      check("stable_addr", out_if.addr, hold_addr);
    end
    if (out_if.vld && out_if.ready) begin
      hs_cyc = cyc;
      hs_total++;
      if (sb_q.size() == 0) check("unexpected_beat", 1, 0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        check("beat_data", out_if.data, e.data);
        check("beat_addr", out_if.addr, e.addr);
      end
    end
    stall_prev = out_if.vld && !out_if.ready;
    hold_data  = out_if.data;
    hold_addr  = out_if.addr;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic tbl_write(input int a, input logic [63:0] b, input logic [63:0] s);
    tbl_we = 1'b1; tbl_addr = a[7:0]; tbl_bias = b; tbl_scale = s;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic send(input int chn, input logic [127:0] d, input logic [15:0] a, input logic [31:0] e);
    int g = 0;
    bit ok = 0;
    in_if.vld = 1'b1; in_if.data = d; in_if.addr = a; in_chn = chn[7:0];
    while (!ok && g < 200) begin
      @(negedge clk);
      if (in_if.ready) ok = 1;
      @(posedge clk);
      g++;
    end
    if (ok) sb_q.push_back('{data: e, addr: a});
    else check("accept_timeout", 0, 1);
    #1;
    in_if.vld = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() != 0 && g < 300) begin tick(); g++; end
    check("drain_timeout", sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    int   k, d0, vs;
    q_shift = 0; q_act = 0; q_start = 0; q_num_words = 0;
    tbl_we = 0; tbl_addr = 0; tbl_bias = 0; tbl_scale = 0; in_chn = 0;
    in_if.vld = 0; in_if.data = 0; in_if.addr = 0; out_if.ready = 1;

    vt[0] = mkvec(1, 1'b0, 0, pk128(7, -7, 1, -1),          pk32('h04, 'hFD, 'h01, 'h00));
    vt[1] = mkvec(4, 1'b0, 1, pk128(1000, 0, -24, 16),      pk32('h7F, 'h05, 'h00, 'h08));
    vt[2] = mkvec(0, 1'b0, 2, pk128(-2000, 42, 100, -40),   pk32('h80, 'h7E, 'h7F, 'h88));
    vt[3] = mkvec(0, 1'b1, 0, pk128(-100, 50, -1, -2000),   pk32('hF3, 'h32, 'hFF, 'h80));
    vt[4] = mkvec(2, 1'b1, 1, pk128(-40, 100, -1000, 8),    pk32('hFE, 'h5D, 'hA4, 'h18));

    repeat (3) tick();
    check("rst_o_vld",  out_if.vld, 0);
    check("rst_o_data", out_if.data, 0);
    check("rst_o_addr", out_if.addr, 0);
    check("rst_o_done", done, 0);
    rstn = 1'b1;
    tick();
    check("rst_in_ready", in_if.ready, 1);

    tbl_write(0, {4{16'd0}},  {4{16'd1}});
    tbl_write(1, {4{16'd24}}, {4{16'd3}});
    tbl_write(2, {4{16'd0}},  {4{16'd3}});

    for (int i = 0; i < 5; i++) begin
      q_shift = vt[i].sh; q_act = vt[i].act;
      send(vt[i].chn, vt[i].ps, 16'h10 + 16'(i), vt[i].ex);
      if (i == 0) begin
        k = 1;
        while (!out_if.vld && k < 10) begin tick(); k++; end
        check("latency", k, 4);
      end
      drain();
    end
    check("no_done_nw0", done_cnt, 0);

    q_shift = 0; q_act = 0;
    d0 = hs_total;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(0, pk128(i*10-40, i*10-39, i*10-38, i*10-37), 16'h100 + 16'(i),
               pk32(i*10-40, i*10-39, i*10-38, i*10-37));
      end
      begin
        for (int j = 0; j < 48; j++) begin
          out_if.ready = (j % 4 == 0) || (j % 4 == 3);
          tick();
        end
        out_if.ready = 1'b1;
      end
    join
    drain();
    check("bp_beats", hs_total - d0, 8);

    q_start = 1; q_num_words = 5;
    tick();
    q_start = 0;
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) send(0, pk128(i, i, i, i), 16'h180 + 16'(i), pk32(i, i, i, i));
    drain();
    repeat (3) tick();
    check("done_once", done_cnt - d0, 1);
    check("done_timing", done_cyc, hs_cyc + 1);

    out_if.ready = 1'b0;
    send(0, pk128(1, 2, 3, 4), 16'h200, pk32(1, 2, 3, 4));
    k = 0;
    while (!out_if.vld && k < 20) begin tick(); k++; end
    tick();
    q_start = 1; q_num_words = 2; out_if.ready = 1'b1;
    tick();
    q_start = 0;
    d0 = done_cnt;
    send(0, pk128(5, 5, 5, 5), 16'h201, pk32(5, 5, 5, 5));
    drain();
    repeat (3) tick();
    check("start_wins_no_done", done_cnt - d0, 0);
    send(0, pk128(6, 6, 6, 6), 16'h202, pk32(6, 6, 6, 6));
    drain();
    repeat (3) tick();
    check("start_wins_done", done_cnt - d0, 1);

    tbl_we = 1; tbl_addr = 3; tbl_bias = {4{16'd0}}; tbl_scale = {4{16'd2}};
    in_if.vld = 1; in_chn = 3; in_if.data = pk128(5, -5, 60, 70); in_if.addr = 16'h300;
    @(negedge clk);
    check("conflict_ready_low", in_if.ready, 0);
    @(posedge clk); #1;
    tbl_we = 0;
    send(3, pk128(5, -5, 60, 70), 16'h300, pk32('h0A, 'hF6, 'h78, 'h7F));
    drain();

    for (int i = 0; i < 3; i++) send(0, pk128(9, 9, 9, 9), 16'h400 + 16'(i), pk32(9, 9, 9, 9));
    rstn = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_o_vld", out_if.vld, 0);
    @(negedge clk);
    check("midrst_o_vld_hold", out_if.vld, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    vs = vld_seen;
    repeat (10) tick();
    check("no_stale_beat", vld_seen - vs, 0);
    check("post_rst_in_ready", in_if.ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
